// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - PC owner, single-outstanding cache fetch, JAL prediction and in-order instruction queue
module instr_fetcher #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rob_clear,
  input  logic [31:0] rob_target_pc,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        cache_valid,
  input  logic [31:0] cache_instr,
  input  logic [31:0] cache_addr,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pred_pc,
  input  logic        dec_ready
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_WAIT = 1'b1;
  localparam logic [6:0]  OP_JAL  = 7'b1101111;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QUEUE_DEPTH);
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [31:0]   req_addr;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic [31:0] q_instr [QUEUE_DEPTH];
  logic [31:0] q_pc    [QUEUE_DEPTH];
  logic [31:0] q_pred  [QUEUE_DEPTH];

  logic [31:0] imm_j;
  logic [31:0] npc;
  logic        enq;
  logic        deq;

  always_comb begin
    imm_j = {{11{cache_instr[31]}}, cache_instr[31], cache_instr[19:12],
             cache_instr[20], cache_instr[30:21], 1'b0};
    npc   = (cache_instr[6:0] == OP_JAL) ? req_addr + imm_j : req_addr + 32'd4;
  end

  // A response only counts if it answers the request currently outstanding
  assign enq = (state == ST_WAIT) && cache_valid && (cache_addr == req_addr);
  assign deq = (count != '0) && dec_ready;

  assign fetch_addr  = req_addr;
  assign dec_valid   = (count != '0);
  assign dec_instr   = dec_valid ? q_instr[head] : 32'h0;
  assign dec_pc      = dec_valid ? q_pc[head]    : 32'h0;
  assign dec_pred_pc = dec_valid ? q_pred[head]  : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      state     <= ST_IDLE;
      req_addr  <= 32'h0;
      fetch_req <= 1'b0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (rdy) begin
      if (rob_clear) begin
        pc        <= rob_target_pc;
        state     <= ST_IDLE;
        fetch_req <= 1'b0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (count < DEPTH_C) begin
              req_addr  <= pc;
              fetch_req <= 1'b1;
              state     <= ST_WAIT;
            end
          end
          default: begin
            if (enq) begin
              pc        <= npc;
              fetch_req <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        endcase
        if (enq) tail <= tail + PTR_ONE;
        if (deq) head <= head + PTR_ONE;
        if (enq && !deq)      count <= count + CNT_ONE;
        else if (deq && !enq) count <= count - CNT_ONE;
      end
    end
  end

  // Queue payload needs no reset: it is only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (rdy && !rob_clear && enq) begin
      q_instr[tail] <= cache_instr;
      q_pc[tail]    <= req_addr;
      q_pred[tail]  <= npc;
    end
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - directed, table-driven bench for instr_fetcher
module tb_instr_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rob_clear;
  logic [31:0] rob_target_pc;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        cache_valid;
  logic [31:0] cache_instr;
  logic [31:0] cache_addr;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pred_pc;
  logic        dec_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pred;
  } vec_t;

  vec_t vecs [7];

  instr_fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rob_clear(rob_clear), .rob_target_pc(rob_target_pc),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .cache_valid(cache_valid), .cache_instr(cache_instr), .cache_addr(cache_addr),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_pred_pc(dec_pred_pc), .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_req_timeout"}, {31'h0, fetch_req}, 32'h1);
  endtask

  task automatic respond(input logic [31:0] instr, input logic [31:0] addr);
    cache_valid = 1'b1;
    cache_instr = instr;
    cache_addr  = addr;
    tick();
    cache_valid = 1'b0;
  endtask

  task automatic flush_to(input logic [31:0] target);
    rob_clear     = 1'b1;
    rob_target_pc = target;
    tick();
    rob_clear     = 1'b0;
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0000_0008, instr: 32'h0100_006F, pred: 32'h0000_0018};
    vecs[1] = '{addr: 32'h0000_0020, instr: 32'hFF9F_F06F, pred: 32'h0000_0018};
    vecs[2] = '{addr: 32'h0000_0040, instr: 32'h0000_0013, pred: 32'h0000_0044};
    vecs[3] = '{addr: 32'h0000_0100, instr: 32'h0080_006F, pred: 32'h0000_0108};
    vecs[4] = '{addr: 32'h0000_0200, instr: 32'h0100_006B, pred: 32'h0000_0204};
    vecs[5] = '{addr: 32'hFFFF_FFFC, instr: 32'h0000_0013, pred: 32'h0000_0000};
    vecs[6] = '{addr: 32'h0000_0004, instr: 32'hFF9F_F06F, pred: 32'hFFFF_FFFC};

    rst = 1'b0; rdy = 1'b1; rob_clear = 1'b0; rob_target_pc = 32'h0;
    cache_valid = 1'b0; cache_instr = 32'h0; cache_addr = 32'h0; dec_ready = 1'b1;
    tick(); tick();
    check("rst_fetch_req", {31'h0, fetch_req}, 32'h0);
    check("rst_fetch_addr", fetch_addr, 32'h0);
    check("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("rst_dec_instr", dec_instr, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_pred", dec_pred_pc, 32'h0);
    rst = 1'b1;

    // Sequential fetch with a 5-cycle cache latency
    for (int i = 0; i < 3; i++) begin
      wait_req("seq");
      check("seq_fetch_addr", fetch_addr, 32'(i * 4));
      repeat (4) tick();
      respond(32'h0000_0013, fetch_addr);
      check("seq_dec_valid", {31'h0, dec_valid}, 32'h1);
      check("seq_dec_pc", dec_pc, 32'(i * 4));
      check("seq_dec_pred", dec_pred_pc, 32'(i * 4 + 4));
      check("seq_req_drop", {31'h0, fetch_req}, 32'h0);
    end

    // Prediction table: redirect, fetch one word, inspect head and next request
    dec_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      flush_to(vecs[i].addr);
      check("vec_flush_empty", {31'h0, dec_valid}, 32'h0);
      wait_req("vec");
      check("vec_fetch_addr", fetch_addr, vecs[i].addr);
      respond(vecs[i].instr, vecs[i].addr);
      check("vec_dec_instr", dec_instr, vecs[i].instr);
      check("vec_dec_pc", dec_pc, vecs[i].addr);
      check("vec_dec_pred", dec_pred_pc, vecs[i].pred);
      wait_req("vec_next");
      check("vec_next_addr", fetch_addr, vecs[i].pred);
    end

    // Backpressure: queue fills to four, then no further requests
    flush_to(32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_req("bp");
      check("bp_fetch_addr", fetch_addr, 32'(i * 4));
      respond(32'h0000_0013, fetch_addr);
    end
    repeat (5) tick();
    check("bp_full_no_req", {31'h0, fetch_req}, 32'h0);
    check("bp_head_pc", dec_pc, 32'h0);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("bp_one_deq_head", dec_pc, 32'h4);
    tick();
    check("bp_new_req", {31'h0, fetch_req}, 32'h1);
    check("bp_new_addr", fetch_addr, 32'h10);
    check("bp_head_hold", dec_pc, 32'h4);

    // Flush while waiting with three entries queued; old response in same cycle
    rob_clear = 1'b1; rob_target_pc = 32'h100;
    cache_valid = 1'b1; cache_instr = 32'h0000_0013; cache_addr = 32'h10;
    tick();
    rob_clear = 1'b0; cache_valid = 1'b0;
    check("fl_dec_valid", {31'h0, dec_valid}, 32'h0);
    check("fl_fetch_req", {31'h0, fetch_req}, 32'h0);
    wait_req("fl");
    check("fl_fetch_addr", fetch_addr, 32'h100);
    check("fl_old_dropped", {31'h0, dec_valid}, 32'h0);

    // Mismatched address is dropped; then rdy=0 freezes a dequeue attempt
    flush_to(32'h40);
    wait_req("mm");
    respond(32'h0000_0013, 32'h44);
    check("mm_still_wait", {31'h0, fetch_req}, 32'h1);
    check("mm_addr_hold", fetch_addr, 32'h40);
    check("mm_no_enq", {31'h0, dec_valid}, 32'h0);
    respond(32'h0000_0013, 32'h40);
    check("mm_match_pc", dec_pc, 32'h40);
    rdy = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_dec_valid", {31'h0, dec_valid}, 32'h1);
      check("rdy_dec_pc", dec_pc, 32'h40);
      check("rdy_no_issue", {31'h0, fetch_req}, 32'h0);
    end
    rdy = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("rdy_deq", {31'h0, dec_valid}, 32'h0);
    check("rdy_issue", {31'h0, fetch_req}, 32'h1);
    check("rdy_pc_kept", fetch_addr, 32'h44);

    // Asynchronous reset mid-WAIT, with a late response held across release
    #2;
    rst = 1'b0;
    #1;
    check("ar_fetch_req", {31'h0, fetch_req}, 32'h0);
    check("ar_fetch_addr", fetch_addr, 32'h0);
    cache_valid = 1'b1; cache_instr = 32'h0000_0013; cache_addr = 32'h44;
    tick();
    rst = 1'b1;
    tick();
    cache_valid = 1'b0;
    wait_req("ar");
    check("ar_first_addr", fetch_addr, 32'h0);
    check("ar_late_ignored", {31'h0, dec_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
